// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares one FIFO write port between N_REQ requesters in the same clock
// domain. Each arbitration winner is selected round-robin. The winner keeps
// the port until it sends a beat flagged last, or until MAX_BURST beats have
// been accepted. Every grant is followed by one IDLE arbitration cycle.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_cg         clock-gate enable; 0 freezes all state and masks transfers
//   i_reqValid   per-requester valid
//   i_reqLast    per-requester end-of-burst flag (qualified by valid)
//   i_reqData    flattened data, requester k at [k*WIDTH +: WIDTH]
//   o_reqReady   per-requester ready, one-hot or zero
//   o_wdata      to FIFO write data
//   o_wvalid     to FIFO write valid
//   i_wready     from FIFO ready (not full)
//   o_grant      index of the current / last granted requester
//   o_busy       1 while a grant is locked
//   o_beatCount  beats accepted in the current grant
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 16,
    localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cg,
    input  logic [N_REQ-1:0]       i_reqValid,
    input  logic [N_REQ-1:0]       i_reqLast,
    input  logic [N_REQ*WIDTH-1:0] i_reqData,
    output logic [N_REQ-1:0]       o_reqReady,
    output logic [WIDTH-1:0]       o_wdata,
    output logic                   o_wvalid,
    input  logic                   i_wready,
    output logic [GW-1:0]          o_grant,
    output logic                   o_busy,
    output logic [CW-1:0]          o_beatCount
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] count_q, count_d;

    logic [GW-1:0] winner;
    logic          found;
    logic          accept;
    logic          release_now;

    // Round-robin scan: first valid requester at or above the pointer,
    // wrapping modulo N_REQ (also correct for non-power-of-2 N_REQ).
    always_comb begin : arb_scan
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && i_reqValid[idx]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        count_d    = count_q;
        o_reqReady = '0;
        o_wdata    = '0;
        o_wvalid   = 1'b0;
        accept     = 1'b0;
        release_now = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_cg && found) begin
                    state_d = LOCKED;
                    grant_d = winner;
                    count_d = '0;
                end
            end
            LOCKED: begin
                o_wvalid            = i_reqValid[grant_q] & i_cg;
                o_wdata             = i_reqData[grant_q*WIDTH +: WIDTH];
                o_reqReady[grant_q] = i_wready & i_cg;
                accept              = i_reqValid[grant_q] & i_wready & i_cg;
                // Last flag and burst cap may coincide; either one releases once.
                release_now = accept &
                              (i_reqLast[grant_q] || (count_q == CW'(MAX_BURST - 1)));
                if (release_now) begin
                    state_d = IDLE;
                    count_d = '0;
                    ptr_d   = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
                end else if (accept) begin
                    count_d = count_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the combinational block above uses blocking ones.
    // NOTE: reset is synchronous and overrides the clock gate; only control
    // state lives here, so there is no storage array to clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            count_q <= '0;
        end else if (i_cg) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_busy      = (state_q == LOCKED);
    assign o_beatCount = count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed bench for fifo_write_arbiter. One instance uses N_REQ=4 with a
// burst cap of 4; a second uses N_REQ=3 to exercise non-power-of-2 wrap.
// Inputs change 1 ns after the rising edge, outputs are sampled 2 ns after.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cg  = 1'b1;
    logic        wready = 1'b1;

    logic [3:0]  valid = '0;
    logic [3:0]  last  = '0;
    logic [31:0] data  = '0;
    logic [3:0]  ready;
    logic [7:0]  wdata;
    logic        wvalid;
    logic [1:0]  grant;
    logic        busy;
    logic [2:0]  beat;

    logic [2:0]  v3 = '0;
    logic [2:0]  l3 = '0;
    logic [23:0] d3 = '0;
    logic [2:0]  ready3;
    logic [7:0]  wdata3;
    logic        wvalid3;
    logic [1:0]  grant3;
    logic        busy3;
    logic [1:0]  beat3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg),
        .i_reqValid(valid), .i_reqLast(last), .i_reqData(data),
        .o_reqReady(ready), .o_wdata(wdata), .o_wvalid(wvalid),
        .i_wready(wready), .o_grant(grant), .o_busy(busy),
        .o_beatCount(beat)
    );

    fifo_write_arbiter #(.N_REQ(3), .WIDTH(8), .MAX_BURST(2)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_cg(cg),
        .i_reqValid(v3), .i_reqLast(l3), .i_reqData(d3),
        .o_reqReady(ready3), .o_wdata(wdata3), .o_wvalid(wvalid3),
        .i_wready(wready), .o_grant(grant3), .o_busy(busy3),
        .o_beatCount(beat3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        data[k*8 +: 8] = v;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        check({tag, "_ready"},  32'(ready),  32'd0);
        check({tag, "_wdata"},  32'(wdata),  32'd0);
    endtask

    task automatic expect_beat(input string tag, input int g,
                               input logic [7:0] d, input int cnt);
        check({tag, "_busy"},   32'(busy),   32'd1);
        check({tag, "_grant"},  32'(grant),  32'(g));
        check({tag, "_wvalid"}, 32'(wvalid), 32'd1);
        check({tag, "_wdata"},  32'(wdata),  32'(d));
        check({tag, "_ready"},  32'(ready),  32'(1) << g);
        check({tag, "_count"},  32'(beat),   32'(cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int n0;

        // Reset state
        cyc();
        rst = 1'b0;
        settle();
        expect_idle("rst");
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_count", 32'(beat),  32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);

        // Single requester: req1 sends A1,A2,A3 with last on the third
        valid[1] = 1'b1;
        set_data(1, 8'hA1);
        settle();
        expect_idle("t1_arb");
        cyc();
        settle();
        expect_beat("t1_b0", 1, 8'hA1, 0);
        cyc();
        set_data(1, 8'hA2);
        settle();
        expect_beat("t1_b1", 1, 8'hA2, 1);
        cyc();
        set_data(1, 8'hA3);
        last[1] = 1'b1;
        settle();
        expect_beat("t1_b2", 1, 8'hA3, 2);
        cyc();
        valid = '0;
        last  = '0;
        settle();
        expect_idle("t1_rel");
        check("t1_rel_grant", 32'(grant), 32'd1);
        check("t1_rel_count", 32'(beat),  32'd0);

        // Round-robin: all valid, 1-beat bursts
        do_reset();
        valid = 4'hF;
        last  = 4'hF;
        for (int k = 0; k < 4; k++) set_data(k, 8'(8'h10 + k));
        for (int i = 0; i < 6; i++) begin
            settle();
            expect_idle($sformatf("t2_idle%0d", i));
            cyc();
            settle();
            expect_beat($sformatf("t2_g%0d", i), i % 4, 8'(8'h10 + i % 4), 0);
            cyc();
        end
        valid = '0;
        last  = '0;

        // Burst cap of 4: req0 never sets last, req2 sends one beat
        do_reset();
        valid = 4'b0101;
        last  = 4'b0100;
        set_data(2, 8'h22);
        n0 = 1;
        set_data(0, 8'(n0));
        settle();
        expect_idle("t3_arb0");
        cyc();
        for (int k = 0; k < 4; k++) begin
            settle();
            expect_beat($sformatf("t3_a%0d", k), 0, 8'(n0), k);
            cyc();
            n0++;
            set_data(0, 8'(n0));
        end
        settle();
        expect_idle("t3_cap");
        check("t3_cap_count", 32'(beat), 32'd0);
        cyc();
        settle();
        expect_beat("t3_r2", 2, 8'h22, 0);
        cyc();
        valid[2] = 1'b0;
        settle();
        expect_idle("t3_arb1");
        cyc();
        for (int k = 0; k < 4; k++) begin
            settle();
            expect_beat($sformatf("t3_b%0d", k), 0, 8'(n0), k);
            cyc();
            n0++;
            set_data(0, 8'(n0));
        end
        valid = '0;
        last  = '0;
        settle();
        expect_idle("t3_end");

        // Backpressure on a req3 burst; last coincides with the cap
        do_reset();
        valid = 4'b1000;
        set_data(3, 8'h31);
        settle();
        expect_idle("t4_arb");
        cyc();
        for (int b = 0; b < 2; b++) begin
            settle();
            expect_beat($sformatf("t4_pre%0d", b), 3, 8'(8'h31 + b), b);
            cyc();
            set_data(3, 8'(8'h32 + b));
        end
        wready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            settle();
            check($sformatf("t4_stall%0d_ready", s), 32'(ready),  32'd0);
            check($sformatf("t4_stall%0d_count", s), 32'(beat),   32'd2);
            check($sformatf("t4_stall%0d_wdata", s), 32'(wdata),  32'h33);
            check($sformatf("t4_stall%0d_busy", s),  32'(busy),   32'd1);
            cyc();
        end
        wready = 1'b1;
        settle();
        expect_beat("t4_post0", 3, 8'h33, 2);
        cyc();
        set_data(3, 8'h34);
        last[3] = 1'b1;
        settle();
        expect_beat("t4_post1", 3, 8'h34, 3);
        cyc();
        valid = '0;
        last  = '0;
        settle();
        expect_idle("t4_end");
        check("t4_end_count", 32'(beat), 32'd0);

        // Clock gate, then reset mid-burst
        valid = 4'b0010;
        last  = 4'b0010;
        set_data(1, 8'h50);
        settle();
        expect_idle("t5_arb0");
        cyc();
        settle();
        expect_beat("t5_one", 1, 8'h50, 0);
        cyc();
        last = '0;
        set_data(1, 8'h51);
        settle();
        expect_idle("t5_arb1");
        cyc();
        settle();
        expect_beat("t5_b0", 1, 8'h51, 0);
        cyc();
        set_data(1, 8'h52);
        settle();
        expect_beat("t5_b1", 1, 8'h52, 1);
        cyc();
        set_data(1, 8'h53);
        cg = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            check($sformatf("t5_cg%0d_wvalid", s), 32'(wvalid), 32'd0);
            check($sformatf("t5_cg%0d_ready", s),  32'(ready),  32'd0);
            check($sformatf("t5_cg%0d_busy", s),   32'(busy),   32'd1);
            check($sformatf("t5_cg%0d_count", s),  32'(beat),   32'd2);
            check($sformatf("t5_cg%0d_grant", s),  32'(grant),  32'd1);
            cyc();
        end
        cg = 1'b1;
        settle();
        expect_beat("t5_b2", 1, 8'h53, 2);
        cyc();
        set_data(1, 8'h54);
        rst = 1'b1;
        settle();
        expect_beat("t5_b3", 1, 8'h54, 3);
        cyc();
        rst   = 1'b0;
        valid = 4'b0111;
        set_data(0, 8'h60);
        settle();
        expect_idle("t5_rst");
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_count", 32'(beat),  32'd0);
        cyc();
        settle();
        expect_beat("t5_win0", 0, 8'h60, 0);
        valid = '0;

        // Non-power-of-2 requester count
        do_reset();
        v3 = 3'b111;
        l3 = 3'b111;
        for (int k = 0; k < 3; k++) d3[k*8 +: 8] = 8'(8'h70 + k);
        for (int i = 0; i < 7; i++) begin
            settle();
            check($sformatf("t6_idle%0d_busy", i),   32'(busy3),   32'd0);
            check($sformatf("t6_idle%0d_wvalid", i), 32'(wvalid3), 32'd0);
            cyc();
            settle();
            check($sformatf("t6_g%0d_busy", i),  32'(busy3),  32'd1);
            check($sformatf("t6_g%0d_grant", i), 32'(grant3), 32'(i % 3));
            check($sformatf("t6_g%0d_wdata", i), 32'(wdata3), 32'(8'h70 + i % 3));
            check($sformatf("t6_g%0d_ready", i), 32'(ready3), 32'(1) << (i % 3));
            cyc();
        end
        v3 = '0;
        l3 = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
